pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Holds the program counter and runs the instruction-fetch handshake of the multicycle CPU.
//   Sits directly downstream of the PC-source mux: its 16-bit pc_next input is the mux output.
//   Commits pc_next on unconditional or branch-qualified writes.
//   On request from the control FSM, fetches the instruction at the current PC over a req/ack
//   memory handshake and latches it into the instruction register.
// PARAMETERS
//   ADDR_WIDTH  16       PC / instruction address width
//   DATA_WIDTH  32       instruction word width
//   RESET_PC    16'h0000 PC value loaded on reset
//   TIMEOUT     8'd64    max cycles in REQ waiting for imem_ack before entering ERR (1..255)
// PORTS
//   clk            in   1           system clock, all logic on rising edge
//   rst            in   1           synchronous reset, active-high
//   pc_next        in   ADDR_WIDTH  candidate PC from the PC-source mux
//   pc_write       in   1           unconditional PC write
//   pc_write_cond  in   1           conditional PC write (branch)
//   branch_ne      in   1           0 = branch taken on alu_zero; 1 = taken on !alu_zero
//   alu_zero       in   1           ALU zero flag
//   fetch_start    in   1           control FSM requests fetch at current pc
//   imem_ack       in   1           memory has driven imem_data for the outstanding request
//   imem_data      in   DATA_WIDTH  instruction word, valid when imem_ack=1
//   pc             out  ADDR_WIDTH  current program counter
//   imem_req       out  1           fetch request, held until ack or timeout
//   imem_addr      out  ADDR_WIDTH  fetch address, stable while imem_req=1
//   ir             out  DATA_WIDTH  instruction register
//   ir_valid       out  1           ir holds a completed fetch
//   fetch_busy     out  1           high in REQ state
//   fetch_done     out  1           one-cycle pulse when ir is loaded
//   fetch_err      out  1           sticky: timeout occurred, cleared only by rst
// BEHAVIOUR
//   Reset values: pc=RESET_PC, imem_req=0, imem_addr=0, ir=0, ir_valid=0, fetch_busy=0,
//     fetch_done=0, fetch_err=0, FSM=IDLE, timeout counter=0.
//     rst has priority over every other input.
//   PC update, every edge:
//     pc <= pc_next if pc_write | (pc_write_cond & (alu_zero ^ branch_ne)); else pc holds.
//     PC updates are legal in any FSM state and never disturb imem_addr.
//   FSM states: IDLE, REQ, ERR.
//     IDLE: on fetch_start, go to REQ.
//       In that same edge: imem_addr<=pc (pre-update value), imem_req<=1, cnt<=0, ir_valid<=0.
//     REQ: imem_ack is sampled only here.
//       On ack: ir<=imem_data, ir_valid<=1, fetch_done<=1 for one cycle, imem_req<=0, go IDLE.
//       No ack: cnt++. When cnt reaches TIMEOUT-1 without ack: imem_req<=0, fetch_err<=1, go ERR.
//     ERR: terminal until rst. fetch_start is ignored. PC updates continue.
//   Latency: fetch_start at edge N -> imem_req high from N+1.
//     Ack sampled at edge M -> ir/ir_valid/fetch_done visible after M; minimum fetch is 2 cycles.
//   Boundary conditions:
//     fetch_start in REQ or ERR: ignored, with no queueing.
//     imem_ack outside REQ: ignored.
//     Ack in the same cycle the counter expires: the ack wins.
//     pc_write and fetch_start in the same cycle: fetch uses the old pc; pc takes pc_next.
//     pc_next wraps naturally at ADDR_WIDTH bits; no arithmetic is done here.
//     rst during REQ: imem_req drops on the reset edge and the fetched data is discarded.
// TESTING
//   1. Reset, then fetch_start; ack after 3 cycles with 32'h8C220004
//      -> imem_addr=0, ir=32'h8C220004, ir_valid=1, fetch_done pulses exactly 1 cycle.
//   2. pc_write_cond=1, branch_ne=0, alu_zero=1, pc_next=16'h0040 -> pc=16'h0040.
//      Same with alu_zero=0 -> pc unchanged.
//      Same with branch_ne=1, alu_zero=0 -> pc=16'h0040.
//   3. pc=16'h0010; fetch_start and pc_write(pc_next=16'h0014) in the same cycle
//      -> imem_addr=16'h0010, pc=16'h0014.
//   4. TIMEOUT=4, no ack -> imem_req drops after 4 REQ cycles, fetch_err=1.
//      A later fetch_start produces no imem_req.
//   5. rst asserted 2 cycles into REQ
//      -> next edge: imem_req=0, ir=0, ir_valid=0, pc=RESET_PC.
//      A late ack after that is ignored.
//   6. Ack arrives on the cycle the counter expires -> ir loaded, fetch_err stays 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter plus the instruction-fetch req/ack handshake into the instruction register.
// Latency: pc commits on the edge it is written; a fetch takes 2+ cycles, fetch_start to ir loaded.
// Backpressure: imem_req is held until imem_ack arrives or TIMEOUT expires; fetch_start outside IDLE is dropped.
module pc_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [7:0]            TIMEOUT    = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  pc_write,
  input  logic                  pc_write_cond,
  input  logic                  branch_ne,
  input  logic                  alu_zero,
  input  logic                  fetch_start,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  ir_valid,
  output logic                  fetch_busy,
  output logic                  fetch_done,
  output logic                  fetch_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  pc_en;

  // PC commit: unconditional write, or a branch whose zero-flag sense matches branch_ne.
  always_comb begin
    pc_en = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));
    pc_d  = pc_en ? pc_next : pc_q;
  end

  // Fetch FSM next-state and datapath; the address is captured from the pre-update pc.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_d      = req_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_start) begin
          state_d    = ST_REQ;
          addr_d     = pc_q;
          req_d      = 1'b1;
          cnt_d      = 8'd0;
          ir_valid_d = 1'b0;
        end
      end
      ST_REQ: begin
        // An ack on the expiry cycle still completes the fetch.
        if (imem_ack) begin
          state_d    = ST_IDLE;
          ir_d       = imem_data;
          ir_valid_d = 1'b1;
          done_d     = 1'b1;
          req_d      = 1'b0;
        end else if (cnt_q == TIMEOUT - 8'd1) begin
          state_d = ST_ERR;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc         = pc_q;
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_busy = (state_q == ST_REQ);
  assign fetch_done = done_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic.
// Every edge is mirrored by a transaction-level model and all outputs are compared 1ns after the edge.
// Inputs are driven right after the compare point, so they are stable well before the next edge.
module tb_pc_fetch_unit;

  localparam int          TO       = 4;
  localparam logic [15:0] RST_PC   = 16'h0000;

  logic        clk;
  logic        rst;
  logic [15:0] pc_next;
  logic        pc_write, pc_write_cond, branch_ne, alu_zero, fetch_start, imem_ack;
  logic [31:0] imem_data;
  logic [15:0] pc, imem_addr;
  logic        imem_req, ir_valid, fetch_busy, fetch_done, fetch_err;
  logic [31:0] ir;

  int checks   = 0;
  int failures = 0;

  // Reference model state: a fetch is "outstanding" or not, with a count of unanswered cycles.
  logic [15:0] m_pc, m_addr;
  logic [31:0] m_ir;
  bit          m_out, m_irv, m_done, m_err;
  int          m_waited;

  pc_fetch_unit #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .RESET_PC(RST_PC), .TIMEOUT(8'(TO))
  ) dut (
    .clk(clk), .rst(rst), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .alu_zero(alu_zero),
    .fetch_start(fetch_start), .imem_ack(imem_ack), .imem_data(imem_data),
    .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .ir(ir),
    .ir_valid(ir_valid), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .fetch_err(fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit fs, input bit pw, input bit pwc,
                       input bit bne, input bit az, input bit ack,
                       input logic [15:0] pn, input logic [31:0] d);
    rst = r; fetch_start = fs; pc_write = pw; pc_write_cond = pwc;
    branch_ne = bne; alu_zero = az; imem_ack = ack; pc_next = pn; imem_data = d;
  endtask

  // Apply the model's view of one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit take;
    if (rst) begin
      m_pc = RST_PC; m_addr = '0; m_ir = '0; m_out = 0; m_irv = 0;
      m_done = 0; m_err = 0; m_waited = 0;
      return;
    end
    take = pc_write || (pc_write_cond && (alu_zero != branch_ne));
    m_done = 0;
    if (m_err) begin
      // stuck until reset
    end else if (!m_out) begin
      if (fetch_start) begin
        m_addr = m_pc; m_out = 1; m_waited = 0; m_irv = 0;
      end
    end else if (imem_ack) begin
      m_ir = imem_data; m_irv = 1; m_done = 1; m_out = 0;
    end else begin
      m_waited++;
      if (m_waited == TO) begin
        m_out = 0; m_err = 1;
      end
    end
    if (take) m_pc = pc_next;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pc",         32'(pc),         32'(m_pc));
    chk("imem_req",   32'(imem_req),   32'(m_out));
    chk("imem_addr",  32'(imem_addr),  32'(m_addr));
    chk("ir",         ir,              m_ir);
    chk("ir_valid",   32'(ir_valid),   32'(m_irv));
    chk("fetch_busy", 32'(fetch_busy), 32'(m_out));
    chk("fetch_done", 32'(fetch_done), 32'(m_done));
    chk("fetch_err",  32'(fetch_err),  32'(m_err));
  endtask

  initial begin
    m_pc = RST_PC; m_addr = '0; m_ir = '0; m_out = 0; m_irv = 0;
    m_done = 0; m_err = 0; m_waited = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0);
    step(); step();
    chk("reset_pc", 32'(pc), 32'(RST_PC));
    chk("reset_req", 32'(imem_req), 32'd0);

    // 1: fetch with ack on the third REQ cycle
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 32'h0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0); step(); step();
    drive(0, 0, 0, 0, 0, 0, 1, 16'h0, 32'h8C220004); step();
    chk("t1_ir", ir, 32'h8C220004);
    chk("t1_addr", 32'(imem_addr), 32'h0);
    chk("t1_done_hi", 32'(fetch_done), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0); step();
    chk("t1_done_lo", 32'(fetch_done), 32'd0);
    chk("t1_valid", 32'(ir_valid), 32'd1);

    // 2: conditional branch writes
    drive(0, 0, 0, 1, 0, 1, 0, 16'h0040, 32'h0); step();
    chk("t2_beq_taken", 32'(pc), 32'h0040);
    drive(0, 0, 0, 1, 0, 0, 0, 16'h0080, 32'h0); step();
    chk("t2_beq_not", 32'(pc), 32'h0040);
    drive(0, 0, 1, 0, 0, 0, 0, 16'h0000, 32'h0); step();
    drive(0, 0, 0, 1, 1, 0, 0, 16'h0040, 32'h0); step();
    chk("t2_bne_taken", 32'(pc), 32'h0040);

    // 3: fetch_start and pc_write together
    drive(0, 0, 1, 0, 0, 0, 0, 16'h0010, 32'h0); step();
    drive(0, 1, 1, 0, 0, 0, 0, 16'h0014, 32'h0); step();
    chk("t3_addr", 32'(imem_addr), 32'h0010);
    chk("t3_pc", 32'(pc), 32'h0014);
    drive(0, 0, 0, 0, 0, 0, 1, 16'h0, 32'h12345678); step();

    // 4: timeout into sticky error
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 32'h0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0); step(); step(); step();
    chk("t4_req_held", 32'(imem_req), 32'd1);
    step();
    chk("t4_req_drop", 32'(imem_req), 32'd0);
    chk("t4_err", 32'(fetch_err), 32'd1);
    drive(0, 1, 0, 0, 0, 0, 1, 16'h0, 32'hFFFF0000); step(); step();
    chk("t4_no_req", 32'(imem_req), 32'd0);
    chk("t4_err_sticky", 32'(fetch_err), 32'd1);

    // 5: reset in the middle of a fetch, then a stray ack
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0); step();
    drive(0, 0, 1, 0, 0, 0, 0, 16'h0200, 32'h0); step();
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 32'h0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0); step(); step();
    drive(1, 0, 0, 0, 0, 0, 1, 16'h0, 32'hDEADBEEF); step();
    chk("t5_req", 32'(imem_req), 32'd0);
    chk("t5_ir", ir, 32'h0);
    chk("t5_pc", 32'(pc), 32'(RST_PC));
    drive(0, 0, 0, 0, 0, 0, 1, 16'h0, 32'hDEADBEEF); step();
    chk("t5_late_ack", 32'(ir_valid), 32'd0);

    // 6: ack on the expiry cycle wins
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 32'h0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0); step(); step(); step();
    drive(0, 0, 0, 0, 0, 0, 1, 16'h0, 32'hCAFEF00D); step();
    chk("t6_ir", ir, 32'hCAFEF00D);
    chk("t6_err", 32'(fetch_err), 32'd0);

    // Random traffic, including pc_next values that exercise the full 16-bit range.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            1'($urandom), 1'($urandom), $urandom_range(0, 4) < 2,
            16'($urandom), $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
